// File: rtl/fetch_pc_unit.sv
// Instruction fetch: owns the PC, keeps at most one imem request outstanding, and presents instr/instr_pc to decode.
// The instruction is valid one edge after the response; it is held until instr_ready is seen or a redirect flushes it.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mux_to_pc,
  input  logic [31:0] branch_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        drop;
  logic        redir;
  logic [31:0] target;
  logic        unused_target_bits;

  assign redir              = mux_to_pc;
  assign target             = {branch_target[31:2], 2'b00};
  assign unused_target_bits = ^branch_target[1:0];

  assign imem_req_valid = (state == ST_REQ) && !redir && !rst;
  assign imem_addr      = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      req_pc      <= 32'h0;
      drop        <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= 32'h0;
    end else begin
      case (state)
        ST_REQ: begin
          if (redir) begin
            pc <= target;
          end else if (imem_req_ready) begin
            req_pc <= pc;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            // A redirect in the response cycle also kills the returning word.
            if (drop || redir) begin
              drop  <= 1'b0;
              state <= ST_REQ;
              if (redir) pc <= target;
            end else begin
              instr       <= imem_resp_data;
              instr_pc    <= req_pc;
              instr_valid <= 1'b1;
              pc          <= pc + 32'd4;
              state       <= ST_HOLD;
            end
          end else if (redir) begin
            drop <= 1'b1;
            pc   <= target;
          end
        end
        ST_HOLD: begin
          if (redir || instr_ready) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            state       <= ST_REQ;
            if (redir) pc <= target;
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit: an epoch-tagged fetch model decides which responses may surface as instructions.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int          NCYC      = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mux_to_pc;
  logic [31:0] branch_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_pc_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst),
    .mux_to_pc(mux_to_pc), .branch_target(branch_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Model: every redirect/reset opens a new epoch; a fetch only delivers if its epoch is still current.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } fetch_t;

  fetch_t      outq[$];
  int          m_epoch;
  logic [31:0] m_pc;
  logic        m_held;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;

  // Memory environment: one pending response, returned 1..3 cycles after acceptance.
  int          mem_cnt;
  logic [31:0] mem_data;

  initial begin
    logic        exp_rv;
    logic        acc;
    logic [31:0] tgt;
    fetch_t      rec;
    int          p_redir, p_ready, p_iready;

    rst = 1'b1; mux_to_pc = 1'b0; branch_target = 32'h0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0; instr_ready = 1'b0;
    m_epoch = 0; m_pc = RESET_PC; m_held = 1'b0; m_instr = NOP_INSTR; m_ipc = 32'h0;
    mem_cnt = 0; mem_data = 32'h0;
    @(posedge clk); #1;

    for (int c = 0; c < NCYC; c++) begin
      // Quiet start reproduces the plain sequential fetch 0,4,8 with zero-wait memory.
      p_redir  = (c < 30) ? 0 : 12;
      p_ready  = (c < 30) ? 100 : 70;
      p_iready = (c < 30) ? 100 : 55;

      rst           = (c < 3) || ((c >= 30) && ($urandom_range(0, 99) < 1));
      mux_to_pc     = ($urandom_range(0, 99) < p_redir);
      branch_target = $urandom;
      if ($urandom_range(0, 3) == 0) branch_target = 32'hFFFF_FFFC | ($urandom & 32'h3);
      imem_req_ready  = (mem_cnt == 0) && ($urandom_range(0, 99) < p_ready);
      imem_resp_valid = (mem_cnt == 1);
      imem_resp_data  = imem_resp_valid ? mem_data : $urandom;
      instr_ready     = ($urandom_range(0, 99) < p_iready);
      #1;

      exp_rv = !rst && !mux_to_pc && (outq.size() == 0) && !m_held;
      check_eq("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      if (exp_rv) check_eq("imem_addr", imem_addr, m_pc);
      acc = imem_req_valid && imem_req_ready;

      @(posedge clk); #1;

      tgt = {branch_target[31:2], 2'b00};
      if (rst) begin
        m_epoch++;
        m_pc   = RESET_PC;
        m_held = 1'b0;
        outq.delete();
      end else begin
        if (mux_to_pc) begin
          m_epoch++;
          m_pc   = tgt;
          m_held = 1'b0;
        end else if (m_held && instr_ready) begin
          m_held = 1'b0;
        end
        if (exp_rv && imem_req_ready) outq.push_back('{addr: m_pc, epoch: m_epoch});
        if (imem_resp_valid && outq.size() > 0) begin
          rec = outq.pop_front();
          if (rec.epoch == m_epoch) begin
            m_held  = 1'b1;
            m_instr = imem_resp_data;
            m_ipc   = rec.addr;
            m_pc    = rec.addr + 32'd4;
          end
        end
      end

      if (acc) begin
        mem_cnt  = $urandom_range(1, 3);
        if (c < 30) mem_cnt = 1;
        mem_data = (c < 30) ? 32'h0010_0093 : $urandom;
      end else if (mem_cnt > 0) begin
        mem_cnt--;
      end

      check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, m_held});
      check_eq("instr", instr, m_held ? m_instr : NOP_INSTR);
      if (m_held) check_eq("instr_pc", instr_pc, m_ipc);
      if (c == 2) check_eq("rst_instr_pc", instr_pc, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
